// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD count sequencer.
// State enum, direction codes, digit limit, BCD validity check.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Callers zero-extend their vector; padding nibbles are valid.
    function automatic logic bcd_valid(input logic [63:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (v[4*i +: 4] > BCD_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: load, step up/down with carry.
// Ports: clk, reset (async low), en, dir, cin, ld, d -> cout, nxt, q.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       cin,
    input  logic       ld,
    input  logic [3:0] d,
    output logic       cout,
    output logic [3:0] nxt,
    output logic [3:0] q
);

    // nxt is the value this digit takes if the chain steps now.
    always_comb begin
        nxt  = q;
        cout = 1'b0;
        if (cin) begin
            unique case (dir)
                DIR_UP: begin
                    if (q == BCD_MAX) begin
                        nxt  = 4'd0;
                        cout = 1'b1;
                    end else begin
                        nxt = q + 4'd1;
                    end
                end
                DIR_DOWN: begin
                    if (q == 4'd0) begin
                        nxt  = BCD_MAX;
                        cout = 1'b1;
                    end else begin
                        nxt = q - 4'd1;
                    end
                end
                default: nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/bcd_count_sequencer.sv
// Command-driven, prescaled BCD up/down counter with run/done control.
// Ports: cmd_* handshake, abort -> count, busy, done, err, cmd_ready.
module bcd_count_sequencer
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int STEP_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic              cmd_load,
    input  logic [4*DIGITS-1:0] cmd_start,
    input  logic [4*DIGITS-1:0] cmd_target,
    input  logic              abort,
    output logic [4*DIGITS-1:0] count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    state_t         state;
    state_t         state_n;
    logic [PW-1:0]  pre;
    logic           dir_q;
    logic [W-1:0]   target_q;
    logic [W-1:0]   nxt_cnt;
    logic [W-1:0]   start_val;
    logic           cmd_ok;
    logic           accept;
    logic           load_en;
    logic           step;
    logic           err_q;
    logic [DIGITS:0] c;

    assign cmd_ok = bcd_valid(64'(cmd_target)) &&
                    (!cmd_load || bcd_valid(64'(cmd_start)));
    assign start_val = cmd_load ? cmd_start : count;
    assign accept    = cmd_valid && (state == S_IDLE);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign err       = err_q;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit u_dig (
            .clk   (clk),
            .reset (reset),
            .en    (step),
            .dir   (dir_q),
            .cin   (c[i]),
            .ld    (load_en),
            .d     (cmd_start[4*i +: 4]),
            .cout  (c[i+1]),
            .nxt   (nxt_cnt[4*i +: 4]),
            .q     (count[4*i +: 4])
        );
    end

    always_comb begin
        state_n = state;
        load_en = 1'b0;
        step    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept && cmd_ok) begin
                    load_en = cmd_load;
                    state_n = (start_val == cmd_target) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort outranks a step landing on the same edge.
                if (abort) begin
                    state_n = S_IDLE;
                end else if (pre == PRE_LAST) begin
                    step = 1'b1;
                    if (nxt_cnt == target_q) state_n = S_DONE;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pre      <= '0;
            dir_q    <= DIR_UP;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= accept && !cmd_ok;
            if (accept && cmd_ok) begin
                dir_q    <= cmd_dir;
                target_q <= cmd_target;
                pre      <= '0;
            end else if (state == S_RUN) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Self-checking bench for bcd_count_sequencer (DIGITS=2, STEP_DIV=4).
// Table vectors, hand sequences and random commands vs. integer model.
module tb_bcd_count_sequencer;

    localparam int DIGITS   = 2;
    localparam int STEP_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic       cmd_load = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cmd_start = 8'h00;
    logic [7:0] cmd_target = 8'h00;
    logic [7:0] count;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int mcount = 0;

    bcd_count_sequencer #(
        .DIGITS   (DIGITS),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_load   (cmd_load),
        .cmd_start  (cmd_start),
        .cmd_target (cmd_target),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       dr;
        logic [7:0] st;
        logic [7:0] tg;
        int         ab;
        bit         hold;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", nm, a, e);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] a,
                        input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %02h want %02h", nm, a, e);
        end
    endtask

    function automatic bit bcd_ok8(input logic [7:0] x);
        return (x[7:4] <= 4'd9) && (x[3:0] <= 4'd9);
    endfunction

    function automatic int dec8(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] tobcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int mstep(input int v, input logic up, input int s);
        if (up) return (v + s) % 100;
        return ((v - s) % 100 + 100) % 100;
    endfunction

    // Issue one command and follow it to completion, abort or rejection.
    task automatic run_cmd(input logic ld, input logic dr,
                           input logic [7:0] st, input logic [7:0] tg,
                           input int ab, input bit hold, input string nm);
        bit ok;
        bit aborted;
        int sv;
        int tv;
        int k;
        int endj;
        int s;
        int v;
        int g;
        ok = bcd_ok8(tg) && (!ld || bcd_ok8(st));
        g = 0;
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        chk1({nm, " ready_wait"}, cmd_ready, 1'b1);
        sv = ld ? dec8(st) : mcount;
        tv = dec8(tg);
        k = dr ? (tv - sv + 100) % 100 : (sv - tv + 100) % 100;
        endj = STEP_DIV * k;
        aborted = (ab > 0) && (ab < endj);
        if (aborted) endj = ab;
        cmd_load   = ld;
        cmd_dir    = dr;
        cmd_start  = st;
        cmd_target = tg;
        cmd_valid  = 1'b1;
        tick();
        if (!ok || !hold || endj == 0) begin
            cmd_valid = 1'b0;
        end else begin
            cmd_load   = 1'b1;
            cmd_start  = 8'h55;
            cmd_target = 8'h55;
        end
        if (!ok) begin
            chk1({nm, " err"}, err, 1'b1);
            chk1({nm, " rej_done"}, done, 1'b0);
            chk1({nm, " rej_busy"}, busy, 1'b0);
            chk1({nm, " rej_ready"}, cmd_ready, 1'b1);
            chk8({nm, " rej_count"}, count, tobcd(mcount));
            tick();
            chk1({nm, " err_drop"}, err, 1'b0);
            chk8({nm, " rej_count2"}, count, tobcd(mcount));
            return;
        end
        v = sv;
        for (int j = 0; j <= endj; j++) begin
            s = (aborted && j == endj) ? (j - 1) / STEP_DIV : j / STEP_DIV;
            v = mstep(sv, dr, s);
            chk8($sformatf("%s count@%0d", nm, j), count, tobcd(v));
            if (j < endj) begin
                chk1($sformatf("%s busy@%0d", nm, j), busy, 1'b1);
                chk1($sformatf("%s done@%0d", nm, j), done, 1'b0);
            end else if (aborted) begin
                chk1({nm, " ab_busy"}, busy, 1'b0);
                chk1({nm, " ab_done"}, done, 1'b0);
                chk1({nm, " ab_ready"}, cmd_ready, 1'b1);
            end else begin
                chk1({nm, " done"}, done, 1'b1);
                chk1({nm, " end_busy"}, busy, 1'b0);
                chk1({nm, " end_ready"}, cmd_ready, 1'b0);
                chk1({nm, " end_err"}, err, 1'b0);
            end
            if (j == endj) break;
            if (j + 1 == endj) begin
                cmd_valid = 1'b0;
                if (aborted) abort = 1'b1;
            end
            tick();
            abort = 1'b0;
        end
        mcount = v;
        if (!aborted) begin
            tick();
            chk1({nm, " post_done"}, done, 1'b0);
            chk1({nm, " post_ready"}, cmd_ready, 1'b1);
            chk8({nm, " post_count"}, count, tobcd(mcount));
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 8'h08, 8'h12, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h98, 8'h01, 0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h01, 8'h98, 0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'h37, 8'h37, 0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h39, 0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h1A, 0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'hA0, 8'h05, 0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'hA0, 8'h45, 0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 8'h00, 8'h05, 12, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 8'h50, 8'h48, 0, 1'b1};

        tick();
        tick();
        reset = 1'b1;
        chk8("rst count", count, 8'h00);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst err", err, 1'b0);
        chk1("rst ready", cmd_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].ld, tbl[i].dr, tbl[i].st, tbl[i].tg,
                    tbl[i].ab, tbl[i].hold, $sformatf("vec%0d", i));
        end

        // Abort while idle has no effect.
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        chk1("idle_abort ready", cmd_ready, 1'b1);
        chk1("idle_abort busy", busy, 1'b0);
        chk8("idle_abort count", count, tobcd(mcount));

        // Asynchronous reset in the middle of a run.
        cmd_load   = 1'b1;
        cmd_dir    = 1'b1;
        cmd_start  = 8'h20;
        cmd_target = 8'h90;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk1("pre_rst busy", busy, 1'b1);
        chk8("pre_rst count", count, 8'h21);
        reset = 1'b0;
        #1;
        chk8("midrst count", count, 8'h00);
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst done", done, 1'b0);
        chk1("midrst ready", cmd_ready, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        mcount = 0;
        run_cmd(1'b0, 1'b1, 8'h00, 8'h02, 0, 1'b0, "after_rst");

        for (int r = 0; r < 25; r++) begin
            logic       ld;
            logic       dr;
            logic [7:0] st;
            logic [7:0] tg;
            int         ab;
            bit         hold;
            ld = 1'($urandom % 2);
            dr = 1'($urandom % 2);
            st = tobcd(int'($urandom % 100));
            tg = tobcd(int'($urandom % 100));
            if ($urandom % 8 == 0) tg[3:0] = 4'(10 + $urandom % 6);
            if ($urandom % 8 == 0) st[7:4] = 4'(10 + $urandom % 6);
            ab = ($urandom % 4 == 0) ? int'($urandom_range(1, 40)) : 0;
            hold = bit'($urandom % 2);
            run_cmd(ld, dr, st, tg, ab, hold, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
